instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the RV32IM core. It owns the program counter and drives the word address into the combinational-read instruction memory. It captures the returned word into a single-entry IF/ID output register with a valid/ready handshake toward decode. It also handles stalls, branch/jump redirects, end-of-program detection (an all-zero word) and out-of-range/misaligned fetch faults.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- MEM_WORDS, 1280, instruction memory depth in 32-bit words (5 KB)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mem_addr  output  32  word address to instruction memory, = {2'b00, pc[31:2]}, combinational from pc register
- mem_instr  input  32  instruction word from memory, combinational response to mem_addr in the same cycle
- redirect_valid  input  1  branch/jump taken; flush and reload pc
- redirect_pc  input  32  byte address of redirect target
- id_ready  input  1  decode accepts id_instr this cycle
- id_valid  output  1  id_instr/id_pc hold a valid instruction
- id_instr  output  32  fetched instruction
- id_pc  output  32  byte address of id_instr
- halted  output  1  all-zero word fetched; fetch stopped
- fault  output  1  illegal fetch address; sticky until reset

## Operation
- States: RUN, HALT, FAULT.
- Output register "free" = !id_valid || id_ready (the handshake completes this cycle).
- RUN, no redirect, free:
  - If pc[1:0]!=0 or pc[31:2] >= MEM_WORDS: go to FAULT, no issue, id_valid<=0.
  - Else if mem_instr==32'h0: go to HALT, no issue, id_valid<=0, pc holds.
  - Else: id_instr<=mem_instr, id_pc<=pc, id_valid<=1, pc<=pc+4 (32-bit wrap, no saturation).
- RUN, not free (stall): pc, id_* hold. The address check and the zero-word check are not evaluated.
- redirect_valid has highest priority in RUN and HALT:
  - pc<=redirect_pc, id_valid<=0, state<=RUN, halted<=0.
  - The target is checked on the following cycle. A misaligned or out-of-range target faults then.
- HALT: pc and id_* frozen, halted=1. Only a redirect leaves HALT.
- FAULT: fault=1, id_valid=0. redirect_valid is ignored. Only reset exits.
- halted is 1 iff state==HALT. fault is 1 iff state==FAULT.

## Timing
- Reset (async assert) values:
  - pc=RESET_PC, state=RUN
  - id_valid=0, id_instr=0, id_pc=0
  - halted=0, fault=0
  - mem_addr=RESET_PC>>2
- First instruction: id_valid=1 after the first rising edge with rst_n high.
- Latency: mem_addr to id_instr is 1 cycle. Throughput is 1 instruction/cycle while id_ready=1.
- Redirect in cycle N: at edge N, id_valid=0 and pc=target. The target instruction is valid after edge N+1, giving a 1-bubble penalty.
- Redirect together with id_valid&&id_ready: the handshake counts as consumed and the register is flushed. Never issue the pre-redirect pc+4 word.
- Reset asserted mid-stall or mid-redirect: all outputs return to reset values immediately (asynchronously). No partial state survives.
- id_instr/id_pc are stable whenever id_valid=1 && id_ready=0.

## Test plan
- Straight-line run:
  - Load words 0..11 with the lw/mul/sub/add/div/sw program; word0=32'h0000_2083, word2=32'h0020_2183; word12=0. Hold id_ready=1.
  - Expect 12 issues with id_pc 0,4,...,44 and matching words.
  - Expect halted=1 one cycle after id_pc=44 is accepted; id_valid=0 thereafter.
- Stall:
  - Drop id_ready for 3 cycles while id_pc=8.
  - Expect id_instr=32'h0020_2183 and mem_addr=3 held for all 3 cycles.
  - Resume: id_pc=12 on the next edge after id_ready rises; no instruction duplicated or skipped.
- Redirect:
  - Assert redirect_valid with redirect_pc=36 while id_pc=12 is valid.
  - Expect id_valid=0 for 1 cycle, then id_pc=36, 40, 44.
  - Expect no issue of id_pc=16.
- Restart from HALT:
  - After halt, redirect_pc=0.
  - Expect halted=0 and id_pc=0 (word0) after 2 edges.
- Faults:
  - redirect_pc=32'h6 (misaligned) → fault=1 next cycle, id_valid=0; a later redirect to 0 is ignored.
  - Reset, then redirect_pc=5120 (word 1280) → fault=1.
- Async reset:
  - Pulse rst_n low mid-cycle while id_valid=1 and stalled.
  - Expect id_valid=0 immediately with no clock edge; pc=RESET_PC on release.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the pc, reads combinational instruction memory and holds
// the fetched word in a single-entry IF/ID register toward decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1280
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        id_valid_n;
    logic [31:0] id_instr_n;
    logic [31:0] id_pc_n;

    logic free;
    logic addr_bad;

    // Handshake: a word transfers to decode on any edge where id_valid && id_ready;
    // while id_valid && !id_ready the register and its payload stay frozen.
    assign free     = !id_valid || id_ready;
    assign addr_bad = (pc[1:0] != 2'b00) || (pc[31:2] >= WORD_LIMIT);
    assign mem_addr = {2'b00, pc[31:2]};

    assign halted = (state == HALT);
    assign fault  = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= 32'h0;
            id_pc    <= 32'h0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            id_valid <= id_valid_n;
            id_instr <= id_instr_n;
            id_pc    <= id_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        id_valid_n = id_valid;
        id_instr_n = id_instr;
        id_pc_n    = id_pc;

        case (state)
            RUN: begin
                if (redirect_valid) begin
                    // Flush wins over a same-cycle handshake; target is checked next cycle.
                    pc_n       = redirect_pc;
                    id_valid_n = 1'b0;
                end else if (free) begin
                    if (addr_bad) begin
                        state_n    = FAULT;
                        id_valid_n = 1'b0;
                    end else if (mem_instr == 32'h0) begin
                        state_n    = HALT;
                        id_valid_n = 1'b0;
                    end else begin
                        id_instr_n = mem_instr;
                        id_pc_n    = pc;
                        id_valid_n = 1'b1;
                        pc_n       = pc + 32'd4;
                    end
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_n    = RUN;
                    pc_n       = redirect_pc;
                    id_valid_n = 1'b0;
                end
            end
            FAULT: begin
                id_valid_n = 1'b0;
            end
            default: begin
                state_n    = FAULT;
                id_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: straight-line run, stall, redirect,
// restart from halt, faults at boundaries and asynchronous reset.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:1279];
    logic [31:0] prog [0:11];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_instr      (mem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .halted         (halted),
        .fault          (fault)
    );

    // clock / reset block
    always #5 clk = ~clk;

    assign mem_instr = (mem_addr < 32'd1280) ? mem[mem_addr[10:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] pc_exp, input logic [31:0] instr_exp);
        chk({tag, "_valid"}, {31'h0, id_valid}, 32'h1);
        chk({tag, "_pc"}, id_pc, pc_exp);
        chk({tag, "_instr"}, id_instr, instr_exp);
    endtask

    initial begin
        prog[0]  = 32'h0000_2083;  // lw  x1,0(x0)
        prog[1]  = 32'h0040_2103;  // lw  x2,4(x0)
        prog[2]  = 32'h0020_2183;  // lw  x3,2(x0)
        prog[3]  = 32'h0220_8233;  // mul x4,x1,x2
        prog[4]  = 32'h4032_02b3;  // sub x5,x4,x3
        prog[5]  = 32'h0012_8333;  // add x6,x5,x1
        prog[6]  = 32'h0223_43b3;  // div x7,x6,x2
        prog[7]  = 32'h0070_2423;  // sw  x7,8(x0)
        prog[8]  = 32'h0020_8433;  // add x8,x1,x2
        prog[9]  = 32'h4034_04b3;  // sub x9,x8,x3
        prog[10] = 32'h0294_8533;  // mul x10,x9,x9
        prog[11] = 32'h00a0_2623;  // sw  x10,12(x0)
        for (int i = 0; i < 1280; i++) mem[i] = 32'h0;
        for (int i = 0; i < 12; i++) mem[i] = prog[i];
        mem[1279] = 32'h0000_0013;

        // reset values, before any edge with rst_n high
        #1 rst_n = 1'b0;
        #7;
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        #4 rst_n = 1'b1;

        // straight-line run through a scoreboard of expected pcs
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 12; i++) begin
            logic [31:0] e;
            step();
            e = exp_q.pop_front();
            expect_issue("run", e, prog[i]);
        end
        step();
        chk("run_halted", {31'h0, halted}, 32'h1);
        chk("run_halt_valid", {31'h0, id_valid}, 32'h0);
        step();
        chk("run_halt_hold", {31'h0, halted}, 32'h1);
        chk("run_halt_hold_valid", {31'h0, id_valid}, 32'h0);

        // restart from halt
        redirect(32'h0);
        chk("restart_halted", {31'h0, halted}, 32'h0);
        chk("restart_bubble", {31'h0, id_valid}, 32'h0);
        step();
        expect_issue("restart", 32'h0, prog[0]);
        step();
        expect_issue("pre_stall4", 32'h4, prog[1]);
        step();
        expect_issue("pre_stall8", 32'h8, prog[2]);

        // stall three cycles holding id_pc=8
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_issue("stall", 32'h8, 32'h0020_2183);
            chk("stall_addr", mem_addr, 32'd3);
        end
        id_ready = 1'b1;
        step();
        expect_issue("resume", 32'd12, prog[3]);

        // redirect while id_pc=12 is valid and accepted
        redirect(32'd36);
        chk("redir_bubble", {31'h0, id_valid}, 32'h0);
        chk("redir_addr", mem_addr, 32'd9);
        step();
        expect_issue("redir36", 32'd36, prog[9]);
        step();
        expect_issue("redir40", 32'd40, prog[10]);
        step();
        expect_issue("redir44", 32'd44, prog[11]);

        // async reset mid-stall, between clock edges
        id_ready = 1'b0;
        step();
        expect_issue("pre_areset", 32'd44, prog[11]);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_valid", {31'h0, id_valid}, 32'h0);
        chk("areset_pc", id_pc, 32'h0);
        chk("areset_instr", id_instr, 32'h0);
        chk("areset_addr", mem_addr, 32'h0);
        #1 rst_n = 1'b1;
        id_ready = 1'b1;
        step();
        expect_issue("areset_restart", 32'h0, prog[0]);

        // misaligned redirect target faults; later redirect ignored
        redirect(32'h6);
        chk("mis_pre_fault", {31'h0, fault}, 32'h0);
        step();
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_valid", {31'h0, id_valid}, 32'h0);
        redirect(32'h0);
        chk("mis_sticky", {31'h0, fault}, 32'h1);
        chk("mis_ignore_addr", mem_addr, 32'h1);
        step();
        chk("mis_sticky2", {31'h0, fault}, 32'h1);
        chk("mis_sticky_valid", {31'h0, id_valid}, 32'h0);

        // last legal word issues, the next word is out of range
        do_reset();
        chk("reset_clears_fault", {31'h0, fault}, 32'h0);
        redirect(32'd5116);
        step();
        expect_issue("last_word", 32'd5116, 32'h0000_0013);
        chk("last_word_fault", {31'h0, fault}, 32'h0);
        step();
        chk("edge_fault", {31'h0, fault}, 32'h1);
        chk("edge_valid", {31'h0, id_valid}, 32'h0);

        // direct redirect to word 1280
        do_reset();
        redirect(32'd5120);
        chk("oor_pre_fault", {31'h0, fault}, 32'h0);
        step();
        chk("oor_fault", {31'h0, fault}, 32'h1);
        chk("oor_halted", {31'h0, halted}, 32'h0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
